shift_register_sipo: RTL and testbench

SHIFT_REGISTER_SIPO -- requirements
Module: shift_register_sipo

---
 rtl/shift_register_sipo.sv | 45 ++++
 tb/tb_shift_register_sipo.sv | 127 ++++++++++++
 2 files changed

// File: rtl/shift_register_sipo.sv
// Serial-in parallel-out shift register with asynchronous active-low reset.
// Optional word-complete strobe: define SIPO_WORD_VALID_EN to add the Valid port.
module shift_register_sipo #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In,
`ifdef SIPO_WORD_VALID_EN
  output logic             Valid,
`endif
  output logic [WIDTH-1:0] Q
);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Q <= '0;
    end else begin
      Q <= {Q[WIDTH-2:0], In};
    end
  end

`ifdef SIPO_WORD_VALID_EN
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] bit_cnt;

  // Valid rises on the edge where the counter wraps, so it lines up with a full fresh word in Q.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bit_cnt <= '0;
      Valid   <= 1'b0;
    end else begin
      Valid <= (bit_cnt == LAST);
      if (bit_cnt == LAST) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_shift_register_sipo.sv
// Directed self-checking bench for shift_register_sipo (WIDTH=4).
// Valid checks are compiled in only when SIPO_WORD_VALID_EN is defined.
module tb_shift_register_sipo;

  logic       Clk;
  logic       Rst_n;
  logic       In;
  logic [3:0] Q;
`ifdef SIPO_WORD_VALID_EN
  logic       Valid;
`endif

  int unsigned n_checks;
  int unsigned n_fail;

  shift_register_sipo #(.WIDTH(4)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .In    (In),
`ifdef SIPO_WORD_VALID_EN
    .Valid (Valid),
`endif
    .Q     (Q)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive In, take one rising edge, leave the sample point 1 time unit after it.
  task automatic step(input logic b);
    In = b;
    @(posedge Clk);
    #1;
  endtask

  // Assert reset away from the edge for two cycles, then release mid-cycle.
  task automatic do_reset();
    #2;
    Rst_n = 1'b0;
    In    = 1'b0;
    #1;
    check("rst_q_immediate", 32'(Q), 32'h0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("rst_q_held", 32'(Q), 32'h0);
`ifdef SIPO_WORD_VALID_EN
    check("rst_valid", 32'(Valid), 32'h0);
`endif
    Rst_n = 1'b1;
  endtask

  logic [3:0] exp_a [8];
  logic [3:0] exp_b [6];
  logic       bits_a [8];
  logic [7:0] v_exp;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Rst_n    = 1'b0;
    In       = 1'b0;
    #1;
    check("por_q", 32'(Q), 32'h0);
    @(posedge Clk); #1;
    check("por_q_after_edge", 32'(Q), 32'h0);
    Rst_n = 1'b1;

    // 1,0,1,1 then 1,0,0,0 from reset
    bits_a = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_a  = '{4'b0001, 4'b0010, 4'b0101, 4'b1011,
               4'b0111, 4'b1110, 4'b1100, 4'b1000};
    for (int i = 0; i < 8; i++) begin
      step(bits_a[i]);
      check($sformatf("word_a_%0d", i), 32'(Q), 32'(exp_a[i]));
    end

    // X on In propagates unfiltered into Q[0]
    step(1'bx);
    check("x_prop", 32'(Q), {28'h0, 4'b000x});

    // Hold In=1 for six edges from reset
    do_reset();
    exp_b = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111};
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      check($sformatf("ones_%0d", i), 32'(Q), 32'(exp_b[i]));
    end

    // Build 1011, then reset mid-cycle: Q clears before the next edge
    step(1'b1); step(1'b0); step(1'b1); step(1'b1);
    check("pre_reset_1011", 32'(Q), 32'b1011);
    do_reset();
    step(1'b1);
    check("first_shift_after_release", 32'(Q), 32'b0001);

`ifdef SIPO_WORD_VALID_EN
    // Eight shifts from reset: Valid only after edges 4 and 8
    do_reset();
    v_exp = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      check($sformatf("valid_run_%0d", i), 32'(Valid), 32'(v_exp[i]));
    end
    // Partial word lost on reset; first pulse after 4th post-reset edge
    do_reset();
    step(1'b1); step(1'b0);
    check("valid_partial", 32'(Valid), 32'h0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      check($sformatf("valid_after_rst_%0d", i), 32'(Valid), (i == 3) ? 32'h1 : 32'h0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
